// File: rtl/dds_hop_scheduler_if.sv
// AXI4-Lite write-only bus between the hop scheduler (master) and the DDS register slave.
// No read channel: only AW, W and B are carried.
interface dds_hop_scheduler_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic [2:0]          M_AXI_AWPROT;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY
  );
endinterface

// File: rtl/dds_hop_scheduler.sv
// Queues DDS hops and replays each as DELTAS then AMPLS AXI-Lite writes followed by a dwell.
// AW/W rise one cycle after start or dwell expiry; valids are held until their ready, hop_ready low when full.
module dds_hop_scheduler #(
  parameter int C_M_AXI_ADDR_WIDTH = 5,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int DEPTH              = 8,
  parameter int DELTAS_ADDR        = 2,
  parameter int AMPLS_ADDR         = 3
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  input  logic                     hop_valid,
  output logic                     hop_ready,
  input  logic [15:0]              hop_delta,
  input  logic [15:0]              hop_ampl,
  input  logic [31:0]              hop_dwell,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [15:0]              hop_count,
  output logic [$clog2(DEPTH):0]   fifo_level,
  dds_hop_scheduler_if.master      m_axi
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [15:0] delta;
    logic [15:0] ampl;
    logic [31:0] dwell;
  } hop_t;

  typedef enum logic [2:0] {IDLE, WR_DELTA, RESP_DELTA, WR_AMPL, RESP_AMPL, DWELL} state_t;

  hop_t                          mem_q [DEPTH];
  hop_t                          head;
  logic [PW-1:0]                 wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]                   cnt_q, cnt_d;
  logic                          push, pop, flush, load_hop;

  state_t                        state_q, state_d;
  logic                          aw_vld_q, aw_vld_d, w_vld_q, w_vld_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [15:0]                   ampl_q, ampl_d;
  logic [31:0]                   dwell_q, dwell_d, dcnt_q, dcnt_d;
  logic [15:0]                   hop_count_q, hop_count_d;
  logic                          err_q, err_d, done_q, done_d;
  logic                          abort_pend_q, abort_pend_d;
  logic                          aw_fire, w_fire, b_fire, abort_now;

  assign hop_ready = (cnt_q != (PW+1)'(DEPTH));
  assign push      = hop_valid && hop_ready;
  assign head      = mem_q[rptr_q];

  assign aw_fire   = aw_vld_q && m_axi.M_AXI_AWREADY;
  assign w_fire    = w_vld_q && m_axi.M_AXI_WREADY;
  assign b_fire    = m_axi.M_AXI_BREADY && m_axi.M_AXI_BVALID;
  assign abort_now = abort || abort_pend_q;

  always_comb begin
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);
    cnt_d  = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (push) mem_q[wptr_q] <= '{delta: hop_delta, ampl: hop_ampl, dwell: hop_dwell};
  end

  always_comb begin
    state_d      = state_q;
    aw_vld_d     = aw_vld_q;
    w_vld_d      = w_vld_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    ampl_d       = ampl_q;
    dwell_d      = dwell_q;
    dcnt_d       = dcnt_q;
    hop_count_d  = hop_count_q;
    err_d        = err_q;
    abort_pend_d = abort_pend_q;
    done_d       = 1'b0;
    pop          = 1'b0;
    flush        = 1'b0;
    load_hop     = 1'b0;

    // An abort mid-transaction is remembered so the bus is drained before returning to IDLE.
    if (abort && state_q != IDLE) begin
      flush        = 1'b1;
      abort_pend_d = 1'b1;
    end
    if (b_fire && m_axi.M_AXI_BRESP != 2'b00) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start && cnt_q != '0) begin
          load_hop    = 1'b1;
          hop_count_d = '0;
          err_d       = 1'b0;
        end
      end
      WR_DELTA, WR_AMPL: begin
        if (aw_fire) aw_vld_d = 1'b0;
        if (w_fire)  w_vld_d  = 1'b0;
        if ((!aw_vld_q || aw_fire) && (!w_vld_q || w_fire))
          state_d = (state_q == WR_DELTA) ? RESP_DELTA : RESP_AMPL;
      end
      RESP_DELTA: begin
        if (b_fire) begin
          if (abort_now) begin
            state_d = IDLE;
          end else begin
            state_d  = WR_AMPL;
            aw_vld_d = 1'b1;
            w_vld_d  = 1'b1;
            awaddr_d = C_M_AXI_ADDR_WIDTH'(AMPLS_ADDR);
            wdata_d  = C_M_AXI_DATA_WIDTH'(ampl_q);
          end
        end
      end
      RESP_AMPL: begin
        if (b_fire) begin
          if (hop_count_q != 16'hFFFF) hop_count_d = hop_count_q + 16'd1;
          state_d = abort_now ? IDLE : DWELL;
          dcnt_d  = (dwell_q == 32'd0) ? 32'd1 : dwell_q;
        end
      end
      DWELL: begin
        if (abort) begin
          state_d = IDLE;
        end else if (dcnt_q <= 32'd1) begin
          if (cnt_q != '0) begin
            load_hop = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_hop) begin
      pop      = 1'b1;
      state_d  = WR_DELTA;
      aw_vld_d = 1'b1;
      w_vld_d  = 1'b1;
      awaddr_d = C_M_AXI_ADDR_WIDTH'(DELTAS_ADDR);
      wdata_d  = C_M_AXI_DATA_WIDTH'(head.delta);
      ampl_d   = head.ampl;
      dwell_d  = head.dwell;
    end
    if (state_d == IDLE) abort_pend_d = 1'b0;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      state_q      <= IDLE;
      aw_vld_q     <= 1'b0;
      w_vld_q      <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      ampl_q       <= '0;
      dwell_q      <= '0;
      dcnt_q       <= '0;
      hop_count_q  <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      aw_vld_q     <= aw_vld_d;
      w_vld_q      <= w_vld_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      ampl_q       <= ampl_d;
      dwell_q      <= dwell_d;
      dcnt_q       <= dcnt_d;
      hop_count_q  <= hop_count_d;
      err_q        <= err_d;
      done_q       <= done_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign hop_count  = hop_count_q;
  assign fifo_level = cnt_q;

  assign m_axi.M_AXI_AWADDR  = awaddr_q;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = aw_vld_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = '1;
  assign m_axi.M_AXI_WVALID  = w_vld_q;
  assign m_axi.M_AXI_BREADY  = (state_q == RESP_DELTA) || (state_q == RESP_AMPL);

endmodule

// File: tb/tb_dds_hop_scheduler.sv
// Directed bench for dds_hop_scheduler with a small AXI-Lite write slave that logs each write.
module tb_dds_hop_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hop_valid = 1'b0;
  logic        hop_ready;
  logic [15:0] hop_delta = '0;
  logic [15:0] hop_ampl = '0;
  logic [31:0] hop_dwell = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, err;
  logic [15:0] hop_count;
  logic [3:0]  fifo_level;

  always #5 clk = ~clk;

  dds_hop_scheduler_if #(.ADDR_W(5), .DATA_W(32)) axi ();

  dds_hop_scheduler #(
    .C_M_AXI_ADDR_WIDTH(5), .C_M_AXI_DATA_WIDTH(32), .DEPTH(8),
    .DELTAS_ADDR(2), .AMPLS_ADDR(3)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .hop_valid(hop_valid), .hop_ready(hop_ready),
    .hop_delta(hop_delta), .hop_ampl(hop_ampl), .hop_dwell(hop_dwell),
    .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .hop_count(hop_count), .fifo_level(fifo_level),
    .m_axi(axi)
  );

  int total = 0;
  int bad = 0;

  int aw_delay = 0, w_delay = 0, err_at = -1, b_num = 0;
  int aw_wait = 0, w_wait = 0, unstable = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_b_cyc = 0;
  logic aw_got = 0, w_got = 0, b_acc = 0, w_first = 0, done_err = 0;
  logic [4:0]  aw_cap = '0;
  logic [31:0] w_cap = '0;
  logic [63:0] wlog[$];

  function automatic logic [63:0] wr(input logic [31:0] a, input logic [31:0] d);
    return {a, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave: drives ready/response at the falling edge so the next rising edge sees stable values.
  initial begin
    axi.M_AXI_AWREADY = 1'b0;
    axi.M_AXI_WREADY  = 1'b0;
    axi.M_AXI_BVALID  = 1'b0;
    axi.M_AXI_BRESP   = 2'b00;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        axi.M_AXI_AWREADY = 1'b0;
        axi.M_AXI_WREADY  = 1'b0;
        axi.M_AXI_BVALID  = 1'b0;
        aw_got = 0; w_got = 0; b_acc = 0; aw_wait = 0; w_wait = 0;
      end else begin
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          done_err = err;
        end
        if (b_acc) begin
          axi.M_AXI_BVALID = 1'b0;
          b_acc = 0; aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0;
        end
        if (!axi.M_AXI_BVALID && aw_got && w_got) begin
          wlog.push_back({27'd0, aw_cap, w_cap});
          axi.M_AXI_BRESP  = (b_num == err_at) ? 2'b10 : 2'b00;
          axi.M_AXI_BVALID = 1'b1;
          b_num++;
        end
        if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) begin
          b_acc = 1;
          last_b_cyc = cyc;
        end
        if (axi.M_AXI_AWVALID && !axi.M_AXI_WVALID) w_first = 1;
        if (axi.M_AXI_AWVALID && !aw_got) begin
          if (aw_wait == 0) aw_cap = axi.M_AXI_AWADDR;
          else if (axi.M_AXI_AWADDR !== aw_cap) unstable++;
          axi.M_AXI_AWREADY = (aw_wait >= aw_delay);
          aw_got = (aw_wait >= aw_delay);
          aw_wait++;
        end else begin
          axi.M_AXI_AWREADY = 1'b0;
        end
        if (axi.M_AXI_WVALID && !w_got) begin
          if (w_wait == 0) w_cap = axi.M_AXI_WDATA;
          else if (axi.M_AXI_WDATA !== w_cap) unstable++;
          axi.M_AXI_WREADY = (w_wait >= w_delay);
          w_got = (w_wait >= w_delay);
          w_wait++;
        end else begin
          axi.M_AXI_WREADY = 1'b0;
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [15:0] a, input logic [31:0] dw);
    hop_valid = 1'b1; hop_delta = d; hop_ampl = a; hop_dwell = dw;
    step();
    hop_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      step();
    end
    chk(tag, busy, 0);
  endtask

  task automatic wait_writes(input string tag, input int n);
    for (int i = 0; i < 300; i++) begin
      if (wlog.size() >= n) break;
      step();
    end
    chk(tag, wlog.size() >= n, 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_awvalid"}, axi.M_AXI_AWVALID, 0);
    chk({tag, "_wvalid"}, axi.M_AXI_WVALID, 0);
    chk({tag, "_bready"}, axi.M_AXI_BREADY, 0);
    chk({tag, "_awaddr"}, axi.M_AXI_AWADDR, 0);
    chk({tag, "_wdata"}, axi.M_AXI_WDATA, 0);
    chk({tag, "_hop_count"}, hop_count, 0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_hop_ready"}, hop_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [63:0] exp2 [6];

    // Reset state
    step(2);
    chk_reset("rst");
    rst_n = 1'b1;
    step();

    // Single hop, always-ready slave
    push(16'h0100, 16'h0004, 32'd10);
    chk("t1_level", fifo_level, 1);
    d0 = done_cnt;
    pulse_start();
    chk("t1_awvalid", axi.M_AXI_AWVALID, 1);
    chk("t1_wvalid", axi.M_AXI_WVALID, 1);
    chk("t1_awaddr", axi.M_AXI_AWADDR, 2);
    chk("t1_wdata", axi.M_AXI_WDATA, 32'h0000_0100);
    chk("t1_wstrb", axi.M_AXI_WSTRB, 4'hF);
    chk("t1_awprot", axi.M_AXI_AWPROT, 0);
    chk("t1_busy", busy, 1);
    wait_idle("t1_idle", 200);
    chk("t1_nwr", wlog.size(), 2);
    chk("t1_wr0", wlog[0], wr(2, 32'h100));
    chk("t1_wr1", wlog[1], wr(3, 32'h4));
    chk("t1_dwell", done_cyc - last_b_cyc, 11);
    chk("t1_hop_count", hop_count, 1);
    step(3);
    chk("t1_done_once", done_cnt - d0, 1);

    // Delayed AWREADY: W completes first, AW held stable
    aw_delay = 3; wlog.delete(); w_first = 0; unstable = 0;
    push(16'h0011, 16'h0022, 32'd2);
    push(16'h0033, 16'h0044, 32'd1);
    push(16'h0055, 16'h0066, 32'd0);
    pulse_start();
    wait_idle("t2_idle", 400);
    exp2[0] = wr(2, 32'h11); exp2[1] = wr(3, 32'h22);
    exp2[2] = wr(2, 32'h33); exp2[3] = wr(3, 32'h44);
    exp2[4] = wr(2, 32'h55); exp2[5] = wr(3, 32'h66);
    chk("t2_nwr", wlog.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t2_wr%0d", i), wlog[i], exp2[i]);
    chk("t2_hop_count", hop_count, 3);
    chk("t2_w_first", w_first, 1);
    chk("t2_stable", unstable, 0);
    chk("t2_dwell0", done_cyc - last_b_cyc, 2);

    // Full FIFO, rejected 9th push, entry pushed mid-run runs as hop 9
    aw_delay = 0; wlog.delete();
    push(16'h0200, 16'h0010, 32'd20);
    for (int i = 1; i < 8; i++) push(16'h0200 + 16'(i), 16'h0010 + 16'(i), 32'd2);
    chk("t3_level_full", fifo_level, 8);
    chk("t3_ready_full", hop_ready, 0);
    push(16'hDEAD, 16'hBEEF, 32'd1);
    chk("t3_level_no9", fifo_level, 8);
    pulse_start();
    wait_writes("t3_first_hop", 2);
    step(3);
    push(16'h0999, 16'h0099, 32'd1);
    chk("t3_level_mid", fifo_level, 8);
    wait_idle("t3_idle", 2000);
    chk("t3_hop_count", hop_count, 9);
    chk("t3_nwr", wlog.size(), 18);
    chk("t3_wr0", wlog[0], wr(2, 32'h200));
    chk("t3_wr15", wlog[15], wr(3, 32'h17));
    chk("t3_wr16", wlog[16], wr(2, 32'h999));
    chk("t3_wr17", wlog[17], wr(3, 32'h99));

    // SLVERR on second write is sticky until the next start
    wlog.delete(); b_num = 0; err_at = 1;
    push(16'h0300, 16'h0030, 32'd2);
    push(16'h0301, 16'h0031, 32'd2);
    d0 = done_cnt;
    pulse_start();
    wait_idle("t4_idle", 300);
    chk("t4_err", err, 1);
    chk("t4_err_at_done", done_err, 1);
    chk("t4_done", done_cnt - d0, 1);
    chk("t4_hop_count", hop_count, 2);
    err_at = -1;
    push(16'h0302, 16'h0032, 32'd1);
    pulse_start();
    chk("t4_err_cleared", err, 0);
    wait_idle("t4_idle2", 200);
    chk("t4_err_clean", err, 0);

    // Abort while AW is stalled: drain the write, flush, no done
    aw_delay = 4; wlog.delete();
    push(16'h0400, 16'h0040, 32'd5);
    push(16'h0401, 16'h0041, 32'd5);
    push(16'h0402, 16'h0042, 32'd5);
    d0 = done_cnt;
    pulse_start();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_flushed", fifo_level, 0);
    chk("t5_aw_held", axi.M_AXI_AWVALID, 1);
    wait_idle("t5_idle", 200);
    chk("t5_nwr", wlog.size(), 1);
    chk("t5_wr0", wlog[0], wr(2, 32'h400));
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_hop_count", hop_count, 0);
    chk("t5_level", fifo_level, 0);

    // Reset mid-dwell, then start with an empty FIFO
    aw_delay = 0; wlog.delete();
    push(16'h0500, 16'h0050, 32'd50);
    pulse_start();
    wait_writes("t6_writes", 2);
    step(5);
    chk("t6_busy_dwell", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset("t6_rst");
    step(2);
    rst_n = 1'b1;
    step();
    d0 = done_cnt;
    pulse_start();
    chk("t6_empty_start", busy, 0);
    step(3);
    chk("t6_still_idle", busy, 0);
    chk("t6_no_done", done_cnt - d0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
